// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response authentication checker.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } puf_state_e;

    localparam int PUF_RESP_W  = 8;
    localparam int PUF_TIMEOUT = 64;

    // Ceiling log2. Returns the number of bits needed to index v distinct values.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/puf_popcount.sv
// Combinational population count of a W-bit vector.
module puf_popcount
    import puf_pkg::*;
#(
    parameter int W = PUF_RESP_W
) (
    input  logic [W-1:0]            vec_i,
    output logic [clog2(W+1)-1:0]   count_o
);

    localparam int CW = clog2(W + 1);

    // Sum the set bits one at a time; synthesis folds this into an adder tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + {{(CW-1){1'b0}}, vec_i[i]};
        end
    end

endmodule

// File: rtl/puf_auth_checker.sv
// Deserializes a W-bit PUF response (LSB first), compares it against a latched
// golden word by Hamming distance and reports pass/fail, with a stall timeout.
module puf_auth_checker
    import puf_pkg::*;
#(
    parameter int W       = PUF_RESP_W,
    parameter int TIMEOUT = PUF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [W-1:0]            expected,
    input  logic [clog2(W+1)-1:0]   hd_threshold,
    input  logic                    resp_bit,
    input  logic                    resp_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [clog2(W+1)-1:0]   hd,
    output logic [W-1:0]            resp_word
);

    localparam int HDW = clog2(W + 1);
    localparam int IW  = clog2(W);
    localparam int SW  = clog2(TIMEOUT);

    puf_state_e        state_q, state_d;
    logic [W-1:0]      exp_q, exp_d;
    logic [HDW-1:0]    thr_q, thr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              pass_q, pass_d;
    logic              tmo_q, tmo_d;
    logic [HDW-1:0]    hd_q, hd_d;
    logic [W-1:0]      word_q, word_d;
    logic [HDW-1:0]    hd_cnt;

    puf_popcount #(.W(W)) u_popcount (
        .vec_i   (word_q ^ exp_q),
        .count_o (hd_cnt)
    );

    // State and result registers; reset discards any partial collection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
            thr_q   <= '0;
            idx_q   <= '0;
            stall_q <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            hd_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            thr_q   <= thr_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            hd_q    <= hd_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic: accept start only when idle, shift in bits, compare once.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        thr_d   = thr_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        hd_d    = hd_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE: begin
                // resp_valid is ignored here, even on the start edge.
                if (start) begin
                    exp_d   = expected;
                    thr_d   = hd_threshold;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    hd_d    = '0;
                    word_d  = '0;
                    idx_d   = '0;
                    stall_d = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (resp_valid) begin
                    word_d[idx_q] = resp_bit;
                    idx_d         = idx_q + 1'b1;
                    stall_d       = '0;
                    if (idx_q == IW'(W - 1)) state_d = COMPARE;
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    // Abort: report worst-case distance, keep the partial word.
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                    hd_d    = HDW'(W);
                    state_d = DONE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            COMPARE: begin
                hd_d    = hd_cnt;
                pass_d  = (hd_cnt <= thr_q);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign timeout   = tmo_q;
    assign hd        = hd_q;
    assign resp_word = word_q;

endmodule

// File: tb/tb_puf_auth_checker.sv
// Directed self-checking bench for puf_auth_checker (W=8, TIMEOUT=64).
module tb_puf_auth_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] expected;
    logic [3:0] hd_threshold;
    logic       resp_bit;
    logic       resp_valid;
    logic       busy, done, pass, timeout;
    logic [3:0] hd;
    logic [7:0] resp_word;

    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;

    puf_auth_checker #(.W(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .expected     (expected),
        .hd_threshold (hd_threshold),
        .resp_bit     (resp_bit),
        .resp_valid   (resp_valid),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .hd           (hd),
        .resp_word    (resp_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start with a coincident valid bit that must not be captured.
    task automatic do_start(input logic [7:0] e, input logic [3:0] t);
        start = 1'b1; expected = e; hd_threshold = t;
        resp_valid = 1'b1; resp_bit = ~e[0];
        tick();
        start = 1'b0; resp_valid = 1'b0;
        expected = 8'h00; hd_threshold = 4'd0;
    endtask

    // Send nbits LSB first with random gaps; optionally pulse start at bit pulse_at.
    task automatic send_bits(input logic [7:0] w, input int nbits, input int maxgap,
                             input int pulse_at);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                resp_valid = 1'b0;
                tick();
            end
            if (i == pulse_at) begin
                start = 1'b1; expected = 8'h00; hd_threshold = 4'd8;
            end
            resp_valid = 1'b1; resp_bit = w[i];
            tick();
            start = 1'b0; expected = 8'h00; hd_threshold = 4'd0;
        end
        resp_valid = 1'b0;
    endtask

    // Called right after the edge that sampled the last bit.
    task automatic finish_chk(input string tag, input logic [7:0] w,
                              input logic [3:0] ehd, input logic epass);
        chk({tag, ".cmp_done"}, done, 1'b0);
        chk({tag, ".cmp_busy"}, busy, 1'b1);
        tick();
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".hd"}, hd, ehd);
        chk({tag, ".pass"}, pass, epass);
        chk({tag, ".timeout"}, timeout, 1'b0);
        chk({tag, ".word"}, resp_word, w);
        tick();
        chk({tag, ".done_low"}, done, 1'b0);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; expected = 8'h00; hd_threshold = 4'd0;
        resp_bit = 1'b0; resp_valid = 1'b0;
        #12;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.pass", pass, 1'b0);
        chk("rst.timeout", timeout, 1'b0);
        chk("rst.hd", hd, 4'd0);
        chk("rst.word", resp_word, 8'h00);
        reset = 1'b0;
        tick();

        // Exact match, threshold 0, consecutive bits.
        do_start(8'hA5, 4'd0);
        chk("t1.busy", busy, 1'b1);
        send_bits(8'hA5, 8, 0, -1);
        finish_chk("t1", 8'hA5, 4'd0, 1'b1);

        // Two and three bits off against threshold 2.
        do_start(8'hA5, 4'd2);
        send_bits(8'hA6, 8, 0, -1);
        finish_chk("t2a", 8'hA6, 4'd2, 1'b1);
        do_start(8'hA5, 4'd2);
        send_bits(8'hA2, 8, 0, -1);
        finish_chk("t2b", 8'hA2, 4'd3, 1'b0);

        // Gapped bits with a start pulse mid-collect that must be ignored.
        do_start(8'h3C, 4'd0);
        dc = done_cnt;
        send_bits(8'h3C, 8, 5, 4);
        finish_chk("t3", 8'h3C, 4'd0, 1'b1);
        repeat (5) tick();
        chk("t3.single_done", done_cnt - dc, 1);

        // Stall timeout after 3 bits.
        do_start(8'hA5, 4'd8);
        send_bits(8'h05, 3, 0, -1);
        repeat (63) tick();
        chk("t4.still_busy", busy, 1'b1);
        chk("t4.no_done_yet", done, 1'b0);
        tick();
        chk("t4.done", done, 1'b1);
        chk("t4.timeout", timeout, 1'b1);
        chk("t4.pass", pass, 1'b0);
        chk("t4.hd", hd, 4'd8);
        chk("t4.word", resp_word, 8'h05);
        tick();
        chk("t4.idle", busy, 1'b0);
        chk("t4.tmo_held", timeout, 1'b1);

        // Asynchronous reset mid-collect.
        do_start(8'hFF, 4'd0);
        chk("t5.tmo_cleared", timeout, 1'b0);
        send_bits(8'hFF, 4, 0, -1);
        chk("t5.partial", resp_word, 8'h0F);
        dc = done_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("t5.busy", busy, 1'b0);
        chk("t5.word", resp_word, 8'h00);
        chk("t5.hd", hd, 4'd0);
        #5;
        reset = 1'b0;
        repeat (3) tick();
        chk("t5.no_done", done_cnt - dc, 0);
        do_start(8'h96, 4'd1);
        send_bits(8'h97, 8, 2, -1);
        finish_chk("t5b", 8'h97, 4'd1, 1'b1);

        // Threshold >= W always passes; results hold while idle.
        do_start(8'hA5, 4'd8);
        send_bits(8'h5A, 8, 0, -1);
        finish_chk("t6", 8'h5A, 4'd8, 1'b1);
        repeat (20) tick();
        chk("t6.hold_hd", hd, 4'd8);
        chk("t6.hold_pass", pass, 1'b1);
        chk("t6.hold_word", resp_word, 8'h5A);
        do_start(8'h00, 4'd0);
        chk("t6.clr_hd", hd, 4'd0);
        chk("t6.clr_pass", pass, 1'b0);
        chk("t6.clr_word", resp_word, 8'h00);
        send_bits(8'h00, 8, 0, -1);
        finish_chk("t7", 8'h00, 4'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
